// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: word width, special encodings and fetch FSM states.
package cpu_pkg;
    localparam int unsigned WORD_W = 16;
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [WORD_W-1:0] NOP_INST = 16'h0000;
    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word that could not enter IF/ID.
module fetch_skid
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    // Flush beats load; a load in the same cycle as a drain refills the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, skid buffer, IF/ID register.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_pc_plus1,
    output logic [WORD_W-1:0] if_inst,
    output logic              if_valid,
    output logic              halted
);

    fetch_state_t state_q, state_d;
    word_t        pc_q;
    word_t        req_pc_q;
    logic         resp;
    logic         resp_halt;
    logic         issue;
    logic         skid_load;
    logic         skid_drain;
    logic         buf_valid;
    fetch_entry_t buf_entry;
    fetch_entry_t resp_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_d    = state_q;
        resp       = (state_q == WAIT) && imem_rvalid;
        resp_halt  = resp && (imem_rdata[15:12] == OP_HALT);
        issue      = ((state_q == FETCH) || resp) && !stall && !buf_valid
                     && !redirect && !rst && !resp_halt;
        skid_load  = resp && !redirect && (stall || buf_valid);
        skid_drain = buf_valid && !stall && !redirect;
        resp_entry = '{pc: req_pc_q, inst: imem_rdata};
        imem_req   = issue;
        imem_addr  = issue ? pc_q : '0;
        halted     = (state_q == HALTED);

        if (redirect) begin
            case (state_q)
                WAIT:    state_d = imem_rvalid ? FETCH : DROP;
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH:   if (issue) state_d = WAIT;
                WAIT:    if (imem_rvalid) state_d = resp_halt ? HALTED : (issue ? WAIT : FETCH);
                DROP:    if (imem_rvalid) state_d = FETCH;
                HALTED:  state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
    end

    fetch_skid u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (redirect),
        .din   (resp_entry),
        .valid (buf_valid),
        .dout  (buf_entry)
    );

    // PC, request tag and IF/ID register; redirect overrides stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
            if_inst     <= NOP_INST;
            if_valid    <= 1'b0;
        end else begin
            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q     <= word_t'(pc_q + 16'd1);
                req_pc_q <= pc_q;
            end

            if (redirect) begin
                if_inst  <= NOP_INST;
                if_valid <= 1'b0;
            end else if (!stall) begin
                if (buf_valid) begin
                    if_pc       <= buf_entry.pc;
                    if_pc_plus1 <= word_t'(buf_entry.pc + 16'd1);
                    if_inst     <= buf_entry.inst;
                    if_valid    <= 1'b1;
                end else if (resp) begin
                    if_pc       <= req_pc_q;
                    if_pc_plus1 <= word_t'(req_pc_q + 16'd1);
                    if_inst     <= imem_rdata;
                    if_valid    <= 1'b1;
                end else begin
                    if_inst  <= NOP_INST;
                    if_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for streaming/stall/redirect, plus DROP, HALT and wrap sequences.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic [15:0] if_inst;
    logic        if_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    int          mem_lat = 1;
    logic        halt_en = 1'b0;
    logic        pend;
    logic [15:0] pend_addr;
    int          cnt;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_pc_plus1 (if_pc_plus1),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_en && a == 16'h0010) return 16'h1000;
        return 16'(16'hC000 + a);
    endfunction

    // Instruction memory with a fixed latency of mem_lat cycles.
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else begin
            if (pend) begin
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(pend_addr);
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req) begin
                if (mem_lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(imem_addr);
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= imem_addr;
                    cnt       <= mem_lat - 1;
                end
            end
        end
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
        logic [15:0] inst;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // stall, redirect, rpc, req, addr, valid, pc, inst
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hC000};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0001, 16'hC001};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hC002};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hC002};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hC002};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'hC002};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0003, 16'hC003};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'hC004};
        vecs[11] = '{1'b1, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'hC005};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0081, 1'b0, 16'h0000, 16'h0000};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0082, 1'b1, 16'h0080, 16'hC080};

        // Reset values.
        mem_lat = 1;
        halt_en = 1'b0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        repeat (3) cyc();
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_addr", imem_addr, 16'h0);
        chk("rst_valid", 16'(if_valid), 16'h0);
        chk("rst_pc", if_pc, 16'h0);
        chk("rst_plus1", if_pc_plus1, 16'h0);
        chk("rst_inst", if_inst, 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        rst = 1'b0;

        // Streaming, 3-cycle stall, redirect+stall with response in flight.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            chk($sformatf("v%0d_req", i), 16'(imem_req), 16'(vecs[i].req));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), 16'(if_valid), 16'(vecs[i].valid));
            chk($sformatf("v%0d_inst", i), if_inst, vecs[i].inst);
            chk($sformatf("v%0d_halted", i), 16'(halted), 16'h0);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_pc", i), if_pc, vecs[i].pc);
                chk($sformatf("v%0d_plus1", i), if_pc_plus1, 16'(vecs[i].pc + 16'd1));
            end
            cyc();
        end

        // 3-cycle memory: redirect while waiting leaves a stale word to drop.
        mem_lat = 3;
        do_reset();
        drive(1'b0, 1'b1, 16'h0005);
        chk("drop_k0_req", 16'(imem_req), 16'h0);
        cyc();
        drive(1'b0, 1'b0, 16'h0);
        chk("drop_k1_req", 16'(imem_req), 16'h1);
        chk("drop_k1_addr", imem_addr, 16'h0005);
        cyc();
        drive(1'b0, 1'b1, 16'h0040);
        chk("drop_k2_req", 16'(imem_req), 16'h0);
        cyc();
        drive(1'b0, 1'b0, 16'h0);
        for (int k = 3; k < 5; k++) begin
            chk($sformatf("drop_k%0d_req", k), 16'(imem_req), 16'h0);
            chk($sformatf("drop_k%0d_valid", k), 16'(if_valid), 16'h0);
            cyc();
        end
        chk("drop_k5_req", 16'(imem_req), 16'h1);
        chk("drop_k5_addr", imem_addr, 16'h0040);
        chk("drop_k5_valid", 16'(if_valid), 16'h0);
        cyc();
        for (int k = 6; k < 8; k++) begin
            chk($sformatf("drop_k%0d_req", k), 16'(imem_req), 16'h0);
            chk($sformatf("drop_k%0d_valid", k), 16'(if_valid), 16'h0);
            cyc();
        end
        chk("drop_k8_addr", imem_addr, 16'h0041);
        chk("drop_k8_valid", 16'(if_valid), 16'h0);
        cyc();
        chk("drop_k9_valid", 16'(if_valid), 16'h1);
        chk("drop_k9_pc", if_pc, 16'h0040);
        chk("drop_k9_inst", if_inst, 16'hC040);

        // HALT fetched at 0x0010, then redirect out of HALTED.
        mem_lat = 1;
        halt_en = 1'b1;
        do_reset();
        drive(1'b0, 1'b1, 16'h000E);
        cyc();
        drive(1'b0, 1'b0, 16'h0);
        chk("halt_k1_addr", imem_addr, 16'h000E);
        cyc();
        chk("halt_k2_addr", imem_addr, 16'h000F);
        cyc();
        chk("halt_k3_addr", imem_addr, 16'h0010);
        chk("halt_k3_pc", if_pc, 16'h000E);
        cyc();
        chk("halt_k4_req", 16'(imem_req), 16'h0);
        chk("halt_k4_pc", if_pc, 16'h000F);
        cyc();
        chk("halt_k5_halted", 16'(halted), 16'h1);
        chk("halt_k5_valid", 16'(if_valid), 16'h1);
        chk("halt_k5_pc", if_pc, 16'h0010);
        chk("halt_k5_inst", if_inst, 16'h1000);
        chk("halt_k5_req", 16'(imem_req), 16'h0);
        cyc();
        for (int k = 6; k < 9; k++) begin
            chk($sformatf("halt_k%0d_req", k), 16'(imem_req), 16'h0);
            chk($sformatf("halt_k%0d_halted", k), 16'(halted), 16'h1);
            chk($sformatf("halt_k%0d_valid", k), 16'(if_valid), 16'h0);
            cyc();
        end
        drive(1'b0, 1'b1, 16'h0020);
        chk("halt_redir_req", 16'(imem_req), 16'h0);
        cyc();
        drive(1'b0, 1'b0, 16'h0);
        chk("halt_exit_halted", 16'(halted), 16'h0);
        chk("halt_exit_req", 16'(imem_req), 16'h1);
        chk("halt_exit_addr", imem_addr, 16'h0020);
        halt_en = 1'b0;

        // PC wrap at 0xFFFF.
        do_reset();
        drive(1'b0, 1'b1, 16'hFFFF);
        cyc();
        drive(1'b0, 1'b0, 16'h0);
        chk("wrap_k1_addr", imem_addr, 16'hFFFF);
        cyc();
        chk("wrap_k2_req", 16'(imem_req), 16'h1);
        chk("wrap_k2_addr", imem_addr, 16'h0000);
        cyc();
        chk("wrap_k3_pc", if_pc, 16'hFFFF);
        chk("wrap_k3_plus1", if_pc_plus1, 16'h0000);
        chk("wrap_k3_inst", if_inst, 16'hBFFF);
        chk("wrap_k3_addr", imem_addr, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipeline, directly upstream of decode. Holds the PC, issues single-outstanding requests to instruction memory, and loads the IF/ID register with PC, PC+1 and the instruction word that decode consumes. Handles hazard stalls, branch/jump redirects from later stages, and stops fetching after a HALT (opcode 4'b0001).

## Interface
- RESET_PC, 16'h0000, PC fetched first after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hazard hold: IF/ID register and PC hold, no new request issued
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  16  target PC when redirect=1
- imem_req  out  1  request strobe; memory accepts in the same cycle
- imem_addr  out  16  request address, valid when imem_req=1
- imem_rvalid  in  1  response strobe; earliest one cycle after request
- imem_rdata  in  16  instruction word when imem_rvalid=1
- if_pc  out  16  PC of instruction in IF/ID
- if_pc_plus1  out  16  if_pc+1, mod 2^16
- if_inst  out  16  instruction word; 16'h0000 when bubble
- if_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped after HALT

## Operation
- States: FETCH (nothing outstanding), WAIT (one live request outstanding), DROP (one stale request outstanding), HALTED.
- Registers: pc (next address), req_pc (address of outstanding request), 1-entry skid buffer (buf_valid, buf_pc, buf_inst), IF/ID register.
- Issue condition: state FETCH, or WAIT with imem_rvalid=1 this cycle; and !stall, !buf_valid, !redirect, !rst, and the returning word (if any) is not HALT. On issue: imem_addr=pc, req_pc<=pc, pc<=pc+1, state->WAIT.
- Response in WAIT: word tagged with req_pc. If !stall and !buf_valid -> IF/ID; else -> skid buffer. If imem_rdata[15:12]==4'b0001 -> HALTED; else WAIT if a new request issued this cycle, else FETCH.
- IF/ID update when !stall: load skid buffer if buf_valid (buf_valid<=0), else the accepted response, else bubble (if_valid=0, if_inst=16'h0000). When stall=1: IF/ID holds.
- Redirect (highest priority, overrides stall): pc<=redirect_pc; IF/ID<-bubble; buf_valid<=0; no issue this cycle. State: WAIT without rvalid -> DROP; WAIT with rvalid -> FETCH (response discarded); HALTED -> FETCH; DROP stays DROP; FETCH stays FETCH.
- DROP: on imem_rvalid discard word, -> FETCH. Never issues.
- HALTED: no requests; IF/ID drains normally under stall; only redirect or rst leaves it. halted=1 iff state HALTED.
- Arithmetic: pc+1 and if_pc_plus1 wrap 16'hFFFF -> 16'h0000.

## Timing
- Reset: pc=RESET_PC, state FETCH, buf_valid=0, if_pc=0, if_pc_plus1=0, if_inst=0, if_valid=0, halted=0, imem_req=0, imem_addr=0 (address forced 0 whenever imem_req=0).
- First request in first cycle after rst deasserts.
- Latency: response in cycle t -> if_valid=1 in cycle t+1 (when !stall).
- Throughput: one instruction per cycle with 1-cycle memory (request re-issued in the response cycle).
- Stall asserted in a response cycle: word goes to skid buffer; appears in IF/ID the first cycle after stall drops.
- Redirect and rvalid same cycle: response dropped; first request to redirect_pc one cycle later.
- rst mid-WAIT: pending response after reset is ignored (state FETCH does not expect one; memory is reset together).

## Structure
- Shared cpu_pkg: OP_HALT=4'b0001, NOP_INST=16'h0000, fetch state enum (FETCH, WAIT, DROP, HALTED), 16-bit word width.
- One sub-module: fetch_skid (1-entry buffer: load, drain, flush, valid/pc/inst out).

## Test plan
- Reset, RESET_PC=16'h0000, 1-cycle memory returning 16'hC000+addr -> requests 0,1,2,... each cycle; if_pc=0 with if_inst=16'hC000 two cycles after reset release, then one per cycle.
- Stall 3 cycles with response in flight -> word held in buffer; IF/ID unchanged during stall; no imem_req; buffered word enters IF/ID first unstalled cycle, PC sequence gapless.
- 3-cycle memory, redirect to 16'h0040 one cycle after request to 16'h0005 -> state DROP, stale word never reaches IF/ID, next request addr 16'h0040.
- Word 16'h1000 (HALT) fetched at 16'h0010 -> IF/ID if_inst=16'h1000, halted=1, imem_req stays 0; later redirect to 16'h0020 -> halted=0, request 16'h0020.
- pc=16'hFFFF -> if_pc_plus1=16'h0000, next request addr 16'h0000.
- Redirect and stall same cycle as rvalid -> IF/ID bubble, response dropped, buffer empty, request to redirect_pc next cycle.
